// File: rtl/pwm_duty_meter_if.sv
// PWM measurement bundle: line and enable toward the meter, recovered duty/period back.
// Source side drives master; the meter attaches to slave.
interface pwm_duty_meter_if #(
    parameter int CNT_W = 24
);
    logic             enable;
    logic             pwm_in;
    logic [7:0]       duty;
    logic             duty_valid;
    logic             stalled;
    logic [CNT_W-1:0] period;

    modport master (output enable, pwm_in, input duty, duty_valid, stalled, period);
    modport slave  (input enable, pwm_in, output duty, duty_valid, stalled, period);
endinterface

// File: rtl/pwm_duty_meter.sv
// Recovers 8-bit duty = floor(high*256/period) from a PWM line and flags a stalled line.
// Result 10 clk after rise detect (3 clk after pin edge); no backpressure, duty_valid is a pulse.
module pwm_duty_meter #(
    parameter int CNT_W   = 24,
    parameter int TIMEOUT = 3_000_000
) (
    input  logic             clk,
    input  logic             reset_n,
    pwm_duty_meter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, MEASURE, DIVIDE, STALL} state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync2_q, prev_q;
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0] p_q, p_d;
    logic [CNT_W:0]   rem_q, rem_d;
    logic [7:0]       quo_q, quo_d;
    logic [3:0]       div_cnt_q, div_cnt_d;
    logic [7:0]       duty_q, duty_d;
    logic             dv_q, dv_d;
    logic             stalled_q, stalled_d;
    logic [CNT_W-1:0] period_q, period_d;

    logic             rise;
    logic [CNT_W:0]   trial;
    logic [CNT_W:0]   diff;
    logic             ge;
    logic [8:0]       quo_next;

    assign rise = sync2_q & ~prev_q;

    // First step tests the integer bit (H <= P), later steps shift the remainder.
    assign trial    = (div_cnt_q == 4'd0) ? rem_q : {rem_q[CNT_W-1:0], 1'b0};
    assign ge       = (trial >= {1'b0, p_q});
    assign diff     = trial - {1'b0, p_q};
    assign quo_next = {quo_q, ge};

    always_comb begin
        state_d    = state_q;
        per_cnt_d  = per_cnt_q;
        high_cnt_d = high_cnt_q;
        p_d        = p_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        div_cnt_d  = div_cnt_q;
        duty_d     = duty_q;
        dv_d       = 1'b0;
        stalled_d  = stalled_q;
        period_d   = period_q;

        if (state_q == MEASURE || state_q == DIVIDE) begin
            if (rise) begin
                per_cnt_d  = {{(CNT_W-1){1'b0}}, 1'b1};
                high_cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                if (per_cnt_q != '1)
                    per_cnt_d = per_cnt_q + 1'b1;
                if (sync2_q && high_cnt_q != '1)
                    high_cnt_d = high_cnt_q + 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                per_cnt_d  = '0;
                high_cnt_d = '0;
                if (rise) begin
                    per_cnt_d  = {{(CNT_W-1){1'b0}}, 1'b1};
                    high_cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
                    state_d    = MEASURE;
                end
            end
            MEASURE: begin
                if (rise) begin
                    p_d       = per_cnt_q;
                    rem_d     = {1'b0, high_cnt_q};
                    quo_d     = '0;
                    div_cnt_d = '0;
                    state_d   = DIVIDE;
                end else if (per_cnt_q >= CNT_W'(TIMEOUT)) begin
                    duty_d    = sync2_q ? 8'hFF : 8'h00;
                    period_d  = '0;
                    stalled_d = 1'b1;
                    dv_d      = 1'b1;
                    state_d   = STALL;
                end
            end
            DIVIDE: begin
                rem_d     = ge ? diff : trial;
                quo_d     = quo_next[7:0];
                div_cnt_d = div_cnt_q + 4'd1;
                if (div_cnt_q == 4'd8) begin
                    duty_d    = quo_next[8] ? 8'hFF : quo_next[7:0];
                    period_d  = p_q;
                    stalled_d = 1'b0;
                    dv_d      = 1'b1;
                    state_d   = MEASURE;
                end
            end
            STALL: begin
                if (rise) begin
                    per_cnt_d  = {{(CNT_W-1){1'b0}}, 1'b1};
                    high_cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
                    state_d    = MEASURE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Disable aborts whatever is in flight but leaves the last reported result visible.
        if (!bus.enable) begin
            state_d   = IDLE;
            dv_d      = 1'b0;
            duty_d    = duty_q;
            period_d  = period_q;
            stalled_d = stalled_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            prev_q     <= 1'b0;
            per_cnt_q  <= '0;
            high_cnt_q <= '0;
            p_q        <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            div_cnt_q  <= '0;
            duty_q     <= '0;
            dv_q       <= 1'b0;
            stalled_q  <= 1'b0;
            period_q   <= '0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= bus.pwm_in;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            per_cnt_q  <= per_cnt_d;
            high_cnt_q <= high_cnt_d;
            p_q        <= p_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            div_cnt_q  <= div_cnt_d;
            duty_q     <= duty_d;
            dv_q       <= dv_d;
            stalled_q  <= stalled_d;
            period_q   <= period_d;
        end
    end

    assign bus.duty       = duty_q;
    assign bus.duty_valid = dv_q;
    assign bus.stalled    = stalled_q;
    assign bus.period     = period_q;
endmodule
